// File: rtl/divider32_if.sv
// divider32_if: start/done request bus between the ALU and the divider.
interface divider32_if;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        signedOp;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        divByZero;

  // ALU side issues requests and consumes results
  modport master (
    output start, dividend, divisor, signedOp,
    input  busy, done, quotient, remainder, divByZero
  );

  // divider side
  modport slave (
    input  start, dividend, divisor, signedOp,
    output busy, done, quotient, remainder, divByZero
  );
endinterface

// File: rtl/divider32.sv
// divider32: multi-cycle 32-bit restoring divider, one quotient bit per cycle.
// Optional feature macro: DIVIDER32_SIGNED_EN (two's-complement divide via signedOp).
// Without it every operation is unsigned; PREP and FIX stay as pass-through states.
module divider32 (
  input  logic         clock,
  input  logic         reset,
  divider32_if.slave   bus
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic [W-1:0]    r;
  logic [W-1:0]    q;
  logic [W-1:0]    b;
  logic [W-1:0]    dvd;
  logic            dbz;
  logic            negq;
  logic            negr;
  logic            busy_q;
  logic            done_q;
  logic [W-1:0]    quotient_q;
  logic [W-1:0]    remainder_q;
  logic            divbyzero_q;

`ifdef DIVIDER32_SIGNED_EN
  logic            sgn;
`else
  assign negq = 1'b0;
  assign negr = 1'b0;
`endif

  logic            c;
  logic [W-1:0]    s;
  logic [W:0]      sub;
  logic            success;
  logic [W-1:0]    q_fix;
  logic [W-1:0]    r_fix;

  // One restoring step: shift R:Q left, trial-subtract the divisor magnitude
  always_comb begin
    c       = r[W-1];
    s       = {r[W-2:0], q[W-1]};
    sub     = {1'b0, s} - {1'b0, b};
    success = c | ~sub[W];
    q_fix   = negq ? (~q + W'(1)) : q;
    r_fix   = negr ? (~r + W'(1)) : r;
  end

  // Sequencer and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      count       <= '0;
      r           <= '0;
      q           <= '0;
      b           <= '0;
      dvd         <= '0;
      dbz         <= 1'b0;
`ifdef DIVIDER32_SIGNED_EN
      sgn         <= 1'b0;
      negq        <= 1'b0;
      negr        <= 1'b0;
`endif
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      divbyzero_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            q      <= bus.dividend;
            b      <= bus.divisor;
            dvd    <= bus.dividend;
`ifdef DIVIDER32_SIGNED_EN
            sgn    <= bus.signedOp;
`endif
            busy_q <= 1'b1;
            state  <= PREP;
          end
        end
        PREP: begin
`ifdef DIVIDER32_SIGNED_EN
          negq <= sgn & (q[W-1] ^ b[W-1]);
          negr <= sgn & q[W-1];
          if (sgn && q[W-1]) q <= ~q + W'(1);
          if (sgn && b[W-1]) b <= ~b + W'(1);
`endif
          dbz   <= (b == '0);
          r     <= '0;
          count <= CW'(31);
          state <= ITER;
        end
        ITER: begin
          r <= success ? sub[W-1:0] : s;
          q <= {q[W-2:0], success};
          if (count == '0) begin
            state <= FIX;
          end else begin
            count <= count - CW'(1);
          end
        end
        FIX: begin
          // Divide by zero reports all-ones and the untouched dividend
          quotient_q  <= dbz ? '1  : q_fix;
          remainder_q <= dbz ? dvd : r_fix;
          divbyzero_q <= dbz;
          busy_q      <= 1'b0;
          done_q      <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.divByZero = divbyzero_q;

endmodule

// File: tb/tb_divider32.sv
// tb_divider32: directed vectors for divider32 with hand-computed results.
module tb_divider32;

  logic clock;
  logic reset;
  int   total;
  int   bad;

  divider32_if bus ();

  divider32 dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // 10 ns clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single comparison point
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request and wait (bounded) for its done pulse
  task automatic run_op(input logic [31:0] a, input logic [31:0] d, input logic sg,
                        output logic [31:0] q, output logic [31:0] r,
                        output logic dz, output int lat);
    bus.dividend = a;
    bus.divisor  = d;
    bus.signedOp = sg;
    bus.start    = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    chk("busy_rise", 32'(bus.busy), 32'd1);
    lat = 0;
    while (lat < 100) begin
      @(posedge clock);
      #1;
      lat++;
      if (bus.done) break;
    end
    q  = bus.quotient;
    r  = bus.remainder;
    dz = bus.divByZero;
    chk("busy_fall", 32'(bus.busy), 32'd0);
    @(posedge clock);
    #1;
    chk("done_pulse", 32'(bus.done), 32'd0);
  endtask

  task automatic vec(input string tag, input logic [31:0] a, input logic [31:0] d,
                     input logic sg, input logic [31:0] eq, input logic [31:0] er,
                     input logic edz);
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
    run_op(a, d, sg, q, r, dz, lat);
    chk({tag, "_lat"}, 32'(lat), 32'd34);
    chk({tag, "_q"}, q, eq);
    chk({tag, "_r"}, r, er);
    chk({tag, "_dz"}, 32'(dz), 32'(edz));
  endtask

  initial begin
    int          n;
    int          dones;
    int          first;
    logic [31:0] fq;
    logic [31:0] fr;

    total        = 0;
    bad          = 0;
    reset        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    bus.signedOp = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_q", bus.quotient, 32'd0);
    chk("rst_r", bus.remainder, 32'd0);
    chk("rst_dz", 32'(bus.divByZero), 32'd0);
    reset = 1'b1;
    @(posedge clock);
    #1;

    vec("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
    vec("umax_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0);
    vec("umax_msb", 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 32'd1, 32'h7FFF_FFFF, 1'b0);
    vec("u_dz", 32'd1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd1234, 1'b1);
    vec("s_dz", 32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1);
`ifdef DIVIDER32_SIGNED_EN
    vec("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    vec("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0);
    vec("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0);
`else
    vec("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'h7FFF_FFFC, 32'd1, 1'b0);
    vec("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'd0, 32'd7, 1'b0);
    vec("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 1'b0);
`endif

    // Second start while busy must be dropped
    bus.dividend = 32'd50;
    bus.divisor  = 32'd5;
    bus.signedOp = 1'b0;
    bus.start    = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    n = 0;
    repeat (4) begin
      @(posedge clock);
      #1;
      n++;
    end
    bus.dividend = 32'd9;
    bus.divisor  = 32'd3;
    bus.start    = 1'b1;
    @(posedge clock);
    #1;
    n++;
    bus.start = 1'b0;
    dones = 0;
    first = 0;
    fq    = '0;
    fr    = '0;
    while (n < 90) begin
      @(posedge clock);
      #1;
      n++;
      if (bus.done) begin
        dones++;
        if (first == 0) begin
          first = n;
          fq    = bus.quotient;
          fr    = bus.remainder;
        end
      end
    end
    chk("busy_ign_dones", 32'(dones), 32'd1);
    chk("busy_ign_lat", 32'(first), 32'd34);
    chk("busy_ign_q", fq, 32'd10);
    chk("busy_ign_r", fr, 32'd0);

    // Reset in the middle of ITER aborts and clears outputs
    bus.dividend = 32'd77;
    bus.divisor  = 32'd4;
    bus.start    = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    repeat (11) @(posedge clock);
    #1;
    chk("mid_busy_pre", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_busy", 32'(bus.busy), 32'd0);
    chk("mid_done", 32'(bus.done), 32'd0);
    chk("mid_q", bus.quotient, 32'd0);
    chk("mid_r", bus.remainder, 32'd0);
    chk("mid_dz", 32'(bus.divByZero), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    vec("post_rst", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
